fma16_mul_sched: RTL and testbench
==================================

Name: fma16_mul_sched

Overview:
- Round-robin scheduler that shares one fp16 multiply datapath among NREQ requesters, using valid/ready on both sides.
- Operands are registered at grant (S1). The multiply runs combinationally from S1 into a result register (S2). Responses return in order, tagged with the requester ID.
- Sits between the fma16 issue logic and the multiply stage, and lets several lanes reuse a single multiplier.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_x  in  NREQ*16  packed fp16 X operands; requester i at [16i+15:16i]
- req_y  in  NREQ*16  packed fp16 Y operands
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accept
- resp_id  out  IDW  requester index of the result
- resp_p  out  16  fp16 product {sign, ex[4:0], frac[9:0]}
- resp_uf  out  1  underflow flag
- resp_of  out  1  overflow flag

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, rr_ptr=0. All response outputs are 0 and req_ready is 0.
- Advance conditions:
  - s2_adv = !s2_valid | resp_ready.
  - s1_adv = !s1_valid | s2_adv.
- Arbitration:
  - grant = first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready = onehot(grant) & s1_adv. It is combinational from req_valid and resp_ready.
- Transfer: when req_valid[g] & req_ready[g] at a clock edge:
  - S1 captures x, y and id=g; s1_valid=1.
  - rr_ptr becomes (g+1) mod NREQ.
  - rr_ptr is unchanged when no transfer occurs.
- S1 to S2: on s2_adv, S2 loads the S1 result and s2_valid=s1_valid. A simultaneous new grant refills S1 in the same cycle, giving full throughput of 1 op/cycle.
- Latency: a transfer at edge N gives resp_valid=1 after edge N+1, provided no stall.
- Stall: while resp_valid & !resp_ready:
  - resp_id, resp_p and the flags hold stable.
  - Once S1 is also full, req_ready is all-zero.
- Arithmetic, computed in S1 from x, y:
  - sign = x[15]^y[15].
  - nz = (exp field != 0); subnormal inputs are treated as zero.
  - m = {nzx, x[9:0]} * {nzy, y[9:0]}, 22 bits.
  - If m[21]: frac=m[20:11]. Otherwise frac=m[19:10]. Truncate, no rounding.
  - e = ex + ey - 15 + m[21], as a 7-bit signed value.
- Result selection, by priority:
  1. Either operand zero: p={sign,15'b0}, uf=0, of=0.
  2. Either exp field==31, or e>=31: p={sign,5'h1F,10'b0}, of=1.
  3. e<=0: p={sign,15'b0}, uf=1.
  4. Otherwise: p={sign,e[4:0],frac}.
- NaN inputs propagate as inf. This is out of scope.
- Reset mid-operation discards S1 and S2 contents; no response is emitted for them.
- A requester dropping req_valid without a handshake is legal; arbitration re-evaluates every cycle.

Optional Feature:
- Macro FMA16_SCHED_STATS_EN.
- When defined, adds outputs:
  - stat_ops (32 bits): increments on each response handshake.
  - stat_stall (32 bits): increments each cycle resp_valid & !resp_ready.
  - stat_conflict (32 bits): increments each cycle more than one req_valid bit is set.
- All three counters reset to 0 and wrap at 2^32.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package fma16_pkg:
  - FP16_BIAS=15, FP16_EXP_MAX=5'h1F.
  - fp16_t packed struct {sign, exp[4:0], frac[9:0]}.
  - mul_res_t struct {p, uf, of}.
- One sub-module, fma16_rr_arb: NREQ request vector + rr_ptr in, one-hot grant + encoded index out.
- Multiply arithmetic lives in a function in fma16_pkg.

Test Plan:
- Single op: req0 sends x=0x3C00, y=0x3C00 → resp_p=0x3C00, id=0, uf=of=0, resp_valid 2 cycles after the handshake.
- Normalization: x=0x3E00, y=0x3E00 → resp_p=0x4080. x=0x4000, y=0x4200 → resp_p=0x4600.
- Flags:
  - 0x7800*0x4000 → 0x7C00 with of=1.
  - 0x0400*0x0400 → 0x0000 with uf=1.
  - 0x8000*0x4000 → 0x8000 with no flags.
- Fairness: all 4 requesters valid continuously, resp_ready=1 → grant order 0,1,2,3,0,1. One response per cycle after fill.
- Backpressure: resp_ready=0 for 3 cycles with 2 ops in flight → resp outputs stable, req_ready=0 by the 2nd stall cycle. Results emerge in order with no loss after resp_ready=1.
- Reset: assert reset_n=0 with S1 and S2 full → resp_valid=0 immediately (async). After release, rr_ptr=0 and req0 wins first.

Source files
------------

// File: rtl/fma16_pkg.sv
// fma16_pkg: shared fp16 types, constants and the truncating fp16 multiply used by fma16_mul_sched
package fma16_pkg;

    localparam int        FP16_BIAS    = 15;
    localparam logic [4:0] FP16_EXP_MAX = 5'h1F;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    typedef struct packed {
        fp16_t p;
        logic  uf;
        logic  of;
    } mul_res_t;

    // Subnormals flush to zero, mantissa product is truncated, exponent tracked as 7-bit signed
    function automatic mul_res_t fp16_mul(input fp16_t a, input fp16_t b);
        mul_res_t          r;
        logic              sign;
        logic              nza;
        logic              nzb;
        logic [21:0]       m;
        logic [9:0]        frac;
        logic signed [6:0] e;
        sign = a.sign ^ b.sign;
        nza  = |a.exp;
        nzb  = |b.exp;
        m    = {nza, a.frac} * {nzb, b.frac};
        frac = m[21] ? m[20:11] : m[19:10];
        e    = {2'b0, a.exp} + {2'b0, b.exp} + {6'b0, m[21]} - 7'(FP16_BIAS);
        r    = '{p: '{sign: sign, exp: 5'd0, frac: 10'd0}, uf: 1'b0, of: 1'b0};
        if (!nza || !nzb) begin
            r.p.exp = 5'd0;
        end else if (a.exp == FP16_EXP_MAX || b.exp == FP16_EXP_MAX || e >= 7'sd31) begin
            r.p.exp = FP16_EXP_MAX;
            r.of    = 1'b1;
        end else if (e <= 7'sd0) begin
            r.uf    = 1'b1;
        end else begin
            r.p.exp  = e[4:0];
            r.p.frac = frac;
        end
        return r;
    endfunction

endpackage

// File: rtl/fma16_rr_arb.sv
// fma16_rr_arb: round-robin pick of the first active request at or above the pointer, wrapping
module fma16_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx
);

    logic w_any;

    // Scan downward so the candidate closest to the pointer is the last (winning) assignment
    always_comb begin
        o_idx = '0;
        w_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_idx = IDW'((int'(i_ptr) + k) % NREQ);
                w_any = 1'b1;
            end
        end
    end

    assign o_gnt = w_any ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/fma16_mul_sched.sv
// fma16_mul_sched: round-robin share of one fp16 multiplier; optional counters via FMA16_SCHED_STATS_EN
module fma16_mul_sched
    import fma16_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*16-1:0] req_x,
    input  logic [NREQ*16-1:0] req_y,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [15:0]       resp_p,
    output logic              resp_uf,
    output logic              resp_of
`ifdef FMA16_SCHED_STATS_EN
    ,
    output logic [31:0]       stat_ops,
    output logic [31:0]       stat_stall,
    output logic [31:0]       stat_conflict
`endif
);

    logic            r_s1_valid;
    logic            r_s2_valid;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_s1_id;
    logic [IDW-1:0]  r_s2_id;
    fp16_t           r_s1_x;
    fp16_t           r_s1_y;
    mul_res_t        r_s2_res;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gidx;
    logic            w_s1_adv;
    logic            w_s2_adv;
    logic            w_xfer;
    mul_res_t        w_mul;

    fma16_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx)
    );

    assign w_s2_adv   = !r_s2_valid || resp_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign req_ready  = w_gnt & {NREQ{w_s1_adv && reset_n}};
    assign w_xfer     = |(req_valid & req_ready);
    assign w_mul      = fp16_mul(r_s1_x, r_s1_y);
    assign resp_valid = r_s2_valid;
    assign resp_id    = r_s2_id;
    assign resp_p     = r_s2_res.p;
    assign resp_uf    = r_s2_res.uf;
    assign resp_of    = r_s2_res.of;

    // Two-stage pipe: S1 holds granted operands, S2 holds the registered product; pointer moves past each winner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_rr_ptr   <= '0;
            r_s1_id    <= '0;
            r_s2_id    <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s2_res   <= '0;
        end else begin
            if (w_s1_adv)
                r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_x   <= req_x[16*w_gidx +: 16];
                r_s1_y   <= req_y[16*w_gidx +: 16];
                r_s1_id  <= w_gidx;
                r_rr_ptr <= (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);
            end
            if (w_s2_adv)
                r_s2_valid <= r_s1_valid;
            if (w_s2_adv && r_s1_valid) begin
                r_s2_res <= w_mul;
                r_s2_id  <= r_s1_id;
            end
        end
    end

`ifdef FMA16_SCHED_STATS_EN
    // Free-running wrap-around counters for handshakes, stalled cycles and multi-request cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_ops      <= '0;
            stat_stall    <= '0;
            stat_conflict <= '0;
        end else begin
            if (r_s2_valid && resp_ready)
                stat_ops <= stat_ops + 32'd1;
            if (r_s2_valid && !resp_ready)
                stat_stall <= stat_stall + 32'd1;
            if ((req_valid & (req_valid - NREQ'(1))) != '0)
                stat_conflict <= stat_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fma16_mul_sched.sv
// tb_fma16_mul_sched: directed and random checks of fma16_mul_sched against a queue-based reference
module tb_fma16_mul_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_x = '0;
    logic [NREQ*16-1:0] req_y = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [IDW-1:0]    resp_id;
    logic [15:0]       resp_p;
    logic              resp_uf;
    logic              resp_of;
`ifdef FMA16_SCHED_STATS_EN
    logic [31:0]       stat_ops;
    logic [31:0]       stat_stall;
    logic [31:0]       stat_conflict;
`endif

    int errors = 0;
    int checks = 0;
    int ptr = 0;
    logic [IDW+17:0] q[$];

    fma16_mul_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .resp_uf    (resp_uf),
        .resp_of    (resp_of)
`ifdef FMA16_SCHED_STATS_EN
        ,
        .stat_ops      (stat_ops),
        .stat_stall    (stat_stall),
        .stat_conflict (stat_conflict)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {of, uf, p} using integer mantissa arithmetic
    function automatic logic [17:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        int   ex, ey, prod, e, f;
        logic s;
        s  = x[15] ^ y[15];
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        if (ex == 0 || ey == 0) return {2'b00, s, 15'd0};
        if (ex == 31 || ey == 31) return {2'b10, s, 15'h7C00};
        prod = (1024 + int'(x[9:0])) * (1024 + int'(y[9:0]));
        if (prod >= 2097152) begin
            e = ex + ey - 14;
            f = (prod / 2048) % 1024;
        end else begin
            e = ex + ey - 15;
            f = (prod / 1024) % 1024;
        end
        if (e >= 31) return {2'b10, s, 15'h7C00};
        if (e <= 0) return {2'b01, s, 15'd0};
        return {2'b00, s, e[4:0], f[9:0]};
    endfunction

    function automatic int ref_grant(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic set_ops(input logic [15:0] x, input logic [15:0] y);
        for (int i = 0; i < NREQ; i++) begin
            req_x[16*i +: 16] = x;
            req_y[16*i +: 16] = y;
        end
    endtask

    // One cycle: drive at negedge, check against the model, then account for the coming posedge
    task automatic step(input logic [NREQ-1:0] v, input logic rr, input logic rnd);
        int              g;
        int              n;
        logic [NREQ-1:0] er;
        logic [IDW+17:0] e;
        @(negedge clk);
        req_valid  = v;
        resp_ready = rr;
        if (rnd)
            for (int i = 0; i < NREQ; i++) begin
                req_x[16*i +: 16] = 16'($urandom);
                req_y[16*i +: 16] = 16'($urandom);
            end
        #1;
        n  = q.size();
        g  = ref_grant(v);
        er = (g >= 0 && (n < 2 || rr)) ? (NREQ'(1) << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        if (n == 2) chk("resp_valid_full", 32'(resp_valid), 32'd1);
        if (resp_valid) begin
            if (n == 0) chk("resp_valid_idle", 32'(resp_valid), 32'd0);
            else begin
                e = q[0];
                chk("resp_id", 32'(resp_id), 32'(e[IDW+17:18]));
                chk("resp_p", 32'(resp_p), 32'(e[15:0]));
                chk("resp_uf", 32'(resp_uf), 32'(e[16]));
                chk("resp_of", 32'(resp_of), 32'(e[17]));
                if (rr) void'(q.pop_front());
            end
        end
        if (er != '0) begin
            q.push_back({IDW'(g), ref_mul(req_x[16*g +: 16], req_y[16*g +: 16])});
            ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic one_op(input logic [15:0] x, input logic [15:0] y, input logic [15:0] ep,
                          input logic euf, input logic eof);
        set_ops(x, y);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        chk("lat_idle", 32'(resp_valid), 32'd0);
        step(4'b0000, 1'b1, 1'b0);
        chk("lat_valid", 32'(resp_valid), 32'd1);
        chk("kat_p", 32'(resp_p), 32'(ep));
        chk("kat_uf", 32'(resp_uf), 32'(euf));
        chk("kat_of", 32'(resp_of), 32'(eof));
        chk("kat_id", 32'(resp_id), 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] fair [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        req_valid = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_p", 32'(resp_p), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;

        one_op(16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 1'b0);
        one_op(16'h3E00, 16'h3E00, 16'h4080, 1'b0, 1'b0);
        one_op(16'h4000, 16'h4200, 16'h4600, 1'b0, 1'b0);
        one_op(16'h7800, 16'h4000, 16'h7C00, 1'b0, 1'b1);
        one_op(16'h0400, 16'h0400, 16'h0000, 1'b1, 1'b0);
        one_op(16'h8000, 16'h4000, 16'h8000, 1'b0, 1'b0);

        step(4'b0001, 1'b1, 1'b1);
        step(4'b0010, 1'b1, 1'b1);
        step(4'b0100, 1'b0, 1'b1);
        #2;
        req_valid = '0;
        reset_n   = 1'b0;
        #1;
        chk("async_rst_valid", 32'(resp_valid), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd0);
        chk("async_rst_id", 32'(resp_id), 32'd0);
        q.delete();
        ptr = 0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            step(4'hF, 1'b1, 1'b1);
            chk("fair_gnt", 32'(req_ready), 32'(fair[k]));
            if (k >= 2) begin
                chk("fair_valid", 32'(resp_valid), 32'd1);
                chk("fair_id", 32'(resp_id), 32'((k - 2) % NREQ));
            end
        end
        repeat (2) step(4'b0000, 1'b1, 1'b0);

        step(4'b0001, 1'b1, 1'b1);
        step(4'b0010, 1'b1, 1'b1);
        step(4'b0100, 1'b0, 1'b1);
        chk("bp_id", 32'(resp_id), 32'd0);
        step(4'b0100, 1'b0, 1'b1);
        chk("bp_ready", 32'(req_ready), 32'd0);
        step(4'b0100, 1'b0, 1'b1);
        chk("bp_hold_valid", 32'(resp_valid), 32'd1);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        repeat (400) step(NREQ'($urandom), $urandom_range(0, 3) != 0, 1'b1);

        for (int i = 0; i < 8 && q.size() > 0; i++) step(4'b0000, 1'b1, 1'b0);
        chk("drained", 32'(q.size()), 32'd0);
        step(4'b0000, 1'b1, 1'b0);
        chk("drain_idle", 32'(resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
